// File: rtl/dcache_port_arb.sv
// Two-requester round-robin arbiter in front of a single dcache port.
// Responses are routed back by an in-order tag FIFO; flushed m0 work is dropped.
module dcache_port_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_req_addr,
    input  logic        m0_req_wr,
    input  logic [31:0] m0_req_wdata,
    input  logic [3:0]  m0_req_wstrb,
    output logic        m0_resp_valid,
    output logic [31:0] m0_resp_data,
    input  logic        m0_resp_ready,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_req_addr,
    input  logic        m1_req_wr,
    input  logic [31:0] m1_req_wdata,
    input  logic [3:0]  m1_req_wstrb,
    output logic        m1_resp_valid,
    output logic [31:0] m1_resp_data,
    input  logic        m1_resp_ready,
    output logic        dc_req_valid,
    input  logic        dc_req_ready,
    output logic [31:0] dc_req_addr,
    output logic        dc_req_wr,
    output logic [31:0] dc_req_wdata,
    output logic [3:0]  dc_req_wstrb,
    input  logic        dc_resp_valid,
    input  logic [31:0] dc_resp_data,
    output logic        dc_resp_ready,
    output logic        busy_o,
    output logic        err_o
);

    logic [2:0] cnt_q, cnt_d;
    logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0] src_q, src_d, kill_q, kill_d;
    logic       last_q, last_d;
    logic       hold_q, hold_d, hold_sel_q, hold_sel_d;
    logic       err_q, err_d;
    logic       ok0, ok1, gnt, space, empty, push, pop, hsrc, hkill;

    assign ok0   = m0_req_valid & ~flush_i;
    assign ok1   = m1_req_valid;
    assign space = cnt_q < 3'(DEPTH);
    assign empty = (cnt_q == 3'd0);
    assign hsrc  = src_q[rptr_q];
    assign hkill = kill_q[rptr_q];

    // A stalled offer keeps its requester as long as it is still eligible.
    always_comb begin
        gnt = ok1;
        if (hold_q && (hold_sel_q ? ok1 : ok0))
            gnt = hold_sel_q;
        else if (ok0 && ok1)
            gnt = ~last_q;
    end

    assign dc_req_valid = rst_n & (ok0 | ok1) & space;
    assign dc_req_addr  = gnt ? m1_req_addr  : m0_req_addr;
    assign dc_req_wr    = gnt ? m1_req_wr    : m0_req_wr;
    assign dc_req_wdata = gnt ? m1_req_wdata : m0_req_wdata;
    assign dc_req_wstrb = gnt ? m1_req_wstrb : m0_req_wstrb;
    assign m0_req_ready = dc_req_valid & ~gnt & dc_req_ready;
    assign m1_req_ready = dc_req_valid & gnt & dc_req_ready;
    assign push         = dc_req_valid & dc_req_ready;

    always_comb begin
        dc_resp_ready = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        if (rst_n) begin
            if (empty || hkill) begin
                dc_resp_ready = 1'b1;
            end else if (hsrc) begin
                dc_resp_ready = m1_resp_ready;
                m1_resp_valid = dc_resp_valid;
            end else begin
                dc_resp_ready = m0_resp_ready;
                m0_resp_valid = dc_resp_valid;
            end
        end
    end

    assign m0_resp_data = dc_resp_data;
    assign m1_resp_data = dc_resp_data;
    assign pop          = dc_resp_valid & dc_resp_ready & ~empty;

    always_comb begin
        src_d  = src_q;
        kill_d = kill_q;
        if (flush_i)
            kill_d = kill_q | ~src_q;
        if (push) begin
            src_d[wptr_q]  = gnt;
            kill_d[wptr_q] = flush_i & ~gnt;
        end
        wptr_d = wptr_q;
        if (push)
            wptr_d = (wptr_q == 2'(DEPTH - 1)) ? 2'd0 : wptr_q + 2'd1;
        rptr_d = rptr_q;
        if (pop)
            rptr_d = (rptr_q == 2'(DEPTH - 1)) ? 2'd0 : rptr_q + 2'd1;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + 3'd1;
        else if (pop && !push)
            cnt_d = cnt_q - 3'd1;
        last_d     = push ? gnt : last_q;
        hold_d     = dc_req_valid & ~dc_req_ready;
        hold_sel_d = gnt;
        err_d      = err_q | (rst_n & dc_resp_valid & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 3'd0;
            wptr_q     <= 2'd0;
            rptr_q     <= 2'd0;
            src_q      <= 4'd0;
            kill_q     <= 4'd0;
            last_q     <= 1'b1;
            hold_q     <= 1'b0;
            hold_sel_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            src_q      <= src_d;
            kill_q     <= kill_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            hold_sel_q <= hold_sel_d;
            err_q      <= err_d;
        end
    end

    assign busy_o = ~empty;
    assign err_o  = err_q;

endmodule

// File: tb/tb_dcache_port_arb.sv
// Bench for dcache_port_arb: directed scenarios with literal expectations,
// then random traffic compared each cycle against a queue-based model.
module tb_dcache_port_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        m0_req_valid, m0_req_ready, m0_req_wr, m0_resp_valid, m0_resp_ready;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_resp_data;
    logic [3:0]  m0_req_wstrb;
    logic        m1_req_valid, m1_req_ready, m1_req_wr, m1_resp_valid, m1_resp_ready;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_resp_data;
    logic [3:0]  m1_req_wstrb;
    logic        dc_req_valid, dc_req_ready, dc_req_wr;
    logic [31:0] dc_req_addr, dc_req_wdata;
    logic [3:0]  dc_req_wstrb;
    logic        dc_resp_valid, dc_resp_ready;
    logic [31:0] dc_resp_data;
    logic        busy_o, err_o;

    always #5 clk = ~clk;

    dcache_port_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready),
        .m0_req_addr(m0_req_addr), .m0_req_wr(m0_req_wr),
        .m0_req_wdata(m0_req_wdata), .m0_req_wstrb(m0_req_wstrb),
        .m0_resp_valid(m0_resp_valid), .m0_resp_data(m0_resp_data),
        .m0_resp_ready(m0_resp_ready),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready),
        .m1_req_addr(m1_req_addr), .m1_req_wr(m1_req_wr),
        .m1_req_wdata(m1_req_wdata), .m1_req_wstrb(m1_req_wstrb),
        .m1_resp_valid(m1_resp_valid), .m1_resp_data(m1_resp_data),
        .m1_resp_ready(m1_resp_ready),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_wr(dc_req_wr),
        .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .dc_resp_ready(dc_resp_ready),
        .busy_o(busy_o), .err_o(err_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: outstanding requests as {src, killed} in issue order.
    bit q_src[$];
    bit q_kill[$];
    bit last_g, held_v, held_s, err_m;
    bit e_sel, e_dcv, e_m0r, e_m1r, e_drr, e_rv0, e_rv1, e_push, e_pop, e_empty;

    task automatic model_reset();
        q_src.delete();
        q_kill.delete();
        last_g = 1'b1;
        held_v = 1'b0;
        held_s = 1'b0;
        err_m  = 1'b0;
    endtask

    task automatic model_eval();
        bit ok0, ok1;
        ok0 = m0_req_valid && !flush_i;
        ok1 = m1_req_valid;
        if (held_v && (held_s ? ok1 : ok0)) e_sel = held_s;
        else if (ok0 && ok1)                e_sel = !last_g;
        else                                e_sel = ok1;
        e_dcv   = (ok0 || ok1) && (q_src.size() < DEPTH);
        e_m0r   = e_dcv && !e_sel && dc_req_ready;
        e_m1r   = e_dcv && e_sel && dc_req_ready;
        e_push  = e_dcv && dc_req_ready;
        e_empty = (q_src.size() == 0);
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        if (e_empty || q_kill[0]) begin
            e_drr = 1'b1;
        end else if (q_src[0]) begin
            e_drr = m1_resp_ready;
            e_rv1 = dc_resp_valid;
        end else begin
            e_drr = m0_resp_ready;
            e_rv0 = dc_resp_valid;
        end
        e_pop = dc_resp_valid && e_drr && !e_empty;
    endtask

    task automatic model_update();
        if (e_pop) begin
            void'(q_src.pop_front());
            void'(q_kill.pop_front());
        end
        if (flush_i)
            foreach (q_src[i]) if (!q_src[i]) q_kill[i] = 1'b1;
        if (e_push) begin
            q_src.push_back(e_sel);
            q_kill.push_back(flush_i && !e_sel);
            last_g = e_sel;
        end
        if (dc_resp_valid && e_empty) err_m = 1'b1;
        held_v = e_dcv && !dc_req_ready;
        held_s = e_sel;
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("dc_req_valid", dc_req_valid, e_dcv);
        chk("m0_req_ready", m0_req_ready, e_m0r);
        chk("m1_req_ready", m1_req_ready, e_m1r);
        chk("dc_resp_ready", dc_resp_ready, e_drr);
        chk("m0_resp_valid", m0_resp_valid, e_rv0);
        chk("m1_resp_valid", m1_resp_valid, e_rv1);
        chk("busy_o", busy_o, !e_empty);
        chk("err_o", err_o, err_m);
        if (e_dcv) begin
            chk("dc_req_addr", dc_req_addr, e_sel ? m1_req_addr : m0_req_addr);
            chk("dc_req_wr", dc_req_wr, e_sel ? m1_req_wr : m0_req_wr);
            chk("dc_req_wdata", dc_req_wdata, e_sel ? m1_req_wdata : m0_req_wdata);
            chk("dc_req_wstrb", dc_req_wstrb, e_sel ? m1_req_wstrb : m0_req_wstrb);
        end
        if (e_rv0) chk("m0_resp_data", m0_resp_data, dc_resp_data);
        if (e_rv1) chk("m1_resp_data", m1_resp_data, dc_resp_data);
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        flush_i = 0;
        m0_req_valid = 0; m0_req_addr = 0; m0_req_wr = 0;
        m0_req_wdata = 0; m0_req_wstrb = 0; m0_resp_ready = 0;
        m1_req_valid = 0; m1_req_addr = 0; m1_req_wr = 0;
        m1_req_wdata = 0; m1_req_wstrb = 0; m1_resp_ready = 0;
        dc_req_ready = 0; dc_resp_valid = 0; dc_resp_data = 0;
    endtask

    task automatic rand_payload();
        m0_req_addr = $urandom; m0_req_wr = 1'($urandom);
        m0_req_wdata = $urandom; m0_req_wstrb = 4'($urandom);
        m1_req_addr = $urandom; m1_req_wr = 1'($urandom);
        m1_req_wdata = $urandom; m1_req_wstrb = 4'($urandom);
    endtask

    task automatic reset_checks();
        chk("rst dc_req_valid", dc_req_valid, 0);
        chk("rst m0_req_ready", m0_req_ready, 0);
        chk("rst m1_req_ready", m1_req_ready, 0);
        chk("rst dc_resp_ready", dc_resp_ready, 0);
        chk("rst m0_resp_valid", m0_resp_valid, 0);
        chk("rst m1_resp_valid", m1_resp_valid, 0);
        chk("rst busy_o", busy_o, 0);
        chk("rst err_o", err_o, 0);
    endtask

    initial begin
        bit b0_exp[6];
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        m0_req_valid = 1; m1_req_valid = 1; dc_req_ready = 1;
        dc_resp_valid = 1; m0_resp_ready = 1; m1_resp_ready = 1;
        #2;
        reset_checks();
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Round-robin alternation with immediate responses.
        m0_req_valid = 1; m1_req_valid = 1; dc_req_ready = 1;
        m0_resp_ready = 1; m1_resp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            dc_resp_valid = (i > 0);
            dc_resp_data  = 32'hA000 + i;
            settle();
            chk("rr m0 grant", m0_req_ready, (i % 2) == 0);
            chk("rr m1 grant", m1_req_ready, (i % 2) == 1);
            if (i > 0) begin
                chk("rr m0 resp", m0_resp_valid, ((i - 1) % 2) == 0);
                chk("rr m1 resp", m1_resp_valid, ((i - 1) % 2) == 1);
            end
            adv();
        end
        m0_req_valid = 0; m1_req_valid = 0; dc_resp_valid = 1;
        settle();
        chk("rr drain m0 resp", m0_resp_valid, 1);
        adv();
        dc_resp_valid = 0;
        settle();
        chk("rr drained busy", busy_o, 0);
        adv();

        // Full FIFO: no accept in the pop cycle, one accept after it.
        b0_exp = '{1, 1, 0, 0, 1, 0};
        m0_req_valid = 1;
        for (int i = 0; i < 6; i++) begin
            rand_payload();
            dc_resp_valid = (i == 3);
            settle();
            chk("full m0_req_ready", m0_req_ready, b0_exp[i]);
            if (i == 3) chk("full resp m0", m0_resp_valid, 1);
            adv();
        end
        chk("full busy", busy_o, 1);

        // Flush with two m0 requests outstanding.
        flush_i = 1;
        settle();
        chk("flush m0 blocked", m0_req_ready, 0);
        adv();
        m0_req_valid = 0; flush_i = 0; m0_resp_ready = 0; dc_resp_valid = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("killed dc_resp_ready", dc_resp_ready, 1);
            chk("killed m0_resp_valid", m0_resp_valid, 0);
            adv();
        end
        dc_resp_valid = 0;
        settle();
        chk("flush drained busy", busy_o, 0);
        adv();

        // m0 then m1 in flight, flush, responses arrive.
        m0_resp_ready = 1; m1_resp_ready = 1;
        m0_req_valid = 1;
        settle();
        chk("order m0 accept", m0_req_ready, 1);
        adv();
        m0_req_valid = 0; m1_req_valid = 1;
        settle();
        chk("order m1 accept", m1_req_ready, 1);
        adv();
        m1_req_valid = 0; flush_i = 1;
        settle();
        adv();
        flush_i = 0; dc_resp_valid = 1; dc_resp_data = 32'h1111_1111;
        settle();
        chk("order discard ready", dc_resp_ready, 1);
        chk("order discard m0", m0_resp_valid, 0);
        chk("order discard m1", m1_resp_valid, 0);
        adv();
        dc_resp_data = 32'hCAFE_F00D;
        settle();
        chk("order m1 resp", m1_resp_valid, 1);
        chk("order m1 data", m1_resp_data, 32'hCAFE_F00D);
        chk("order m0 idle", m0_resp_valid, 0);
        adv();
        dc_resp_valid = 0;

        // Stalled m1 offer keeps grant and payload while m0 competes.
        m1_req_valid = 1; dc_req_ready = 0;
        m1_req_addr = 32'h0000_1234; m0_req_addr = 32'h0000_5678;
        settle();
        chk("hold valid", dc_req_valid, 1);
        chk("hold addr0", dc_req_addr, 32'h1234);
        adv();
        m0_req_valid = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("hold addr", dc_req_addr, 32'h1234);
            chk("hold m0 ready", m0_req_ready, 0);
            adv();
        end
        dc_req_ready = 1;
        settle();
        chk("hold m1 accept", m1_req_ready, 1);
        chk("hold addr final", dc_req_addr, 32'h1234);
        adv();
        settle();
        chk("after hold m0 grant", m0_req_ready, 1);
        chk("after hold addr", dc_req_addr, 32'h5678);
        adv();
        m0_req_valid = 0; m1_req_valid = 0; dc_resp_valid = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            adv();
        end
        dc_resp_valid = 0;
        settle();
        chk("hold drained busy", busy_o, 0);
        adv();

        // Spurious response sets the sticky error.
        dc_resp_valid = 1;
        settle();
        chk("spur err before", err_o, 0);
        chk("spur ready", dc_resp_ready, 1);
        adv();
        dc_resp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("spur err sticky", err_o, 1);
            adv();
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_payload();
            m0_req_valid  = ($urandom_range(3) != 0);
            m1_req_valid  = ($urandom_range(2) != 0);
            flush_i       = ($urandom_range(9) == 0);
            dc_req_ready  = ($urandom_range(3) != 0);
            dc_resp_valid = ($urandom_range(1) != 0);
            dc_resp_data  = $urandom;
            m0_resp_ready = ($urandom_range(3) != 0);
            m1_resp_ready = ($urandom_range(3) != 0);
            settle();
            adv();
        end

        // Reset clears the sticky error.
        rst_n = 1'b0;
        model_reset();
        m0_req_valid = 1; m1_req_valid = 1; dc_req_ready = 1;
        dc_resp_valid = 1; flush_i = 0;
        #1;
        reset_checks();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        settle();
        chk("post reset err", err_o, 0);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_port_arb.md
DCACHE_PORT_ARB -- requirements
Module: dcache_port_arb

Interface
REQ-001 Parameter DEPTH, default 2: maximum number of dcache requests in flight; legal range 1..4.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 flush_i  in  1  pipeline flush; kills all requester-0 work.
REQ-005 m0_req_valid, m0_req_ready  in/out  1  requester 0 (Memory1 load/store) request handshake.
REQ-006 m0_req_addr  in  32; m0_req_wr  in  1; m0_req_wdata  in  32; m0_req_wstrb  in  4.
REQ-007 m0_resp_valid  out  1; m0_resp_data  out  32; m0_resp_ready  in  1: response to Memory2.
REQ-008 m1_req_valid, m1_req_ready, m1_req_addr, m1_req_wr, m1_req_wdata, m1_req_wstrb: requester 1 (cache-op unit), same widths as m0.
REQ-009 m1_resp_valid  out  1; m1_resp_data  out  32; m1_resp_ready  in  1.
REQ-010 dc_req_valid  out  1; dc_req_ready  in  1; dc_req_addr/wr/wdata/wstrb  out  32/1/32/4: dcache request channel.
REQ-011 dc_resp_valid  in  1; dc_resp_data  in  32; dc_resp_ready  out  1: dcache response channel.
REQ-012 busy_o  out  1: at least one request in flight.
REQ-013 err_o  out  1: sticky protocol error.

Function
REQ-014 Every accepted dcache request (dc_req_valid & dc_req_ready) returns exactly one dcache response, in order.
REQ-015 Tag FIFO, DEPTH entries, each entry {src (0/1), killed}; pushed on dcache request acceptance, popped on dcache response handshake.
REQ-016 Occupancy counter cnt, 0..DEPTH; +1 on push, -1 on pop, unchanged on simultaneous push and pop.
REQ-017 No grant when cnt == DEPTH, even if a pop occurs that cycle.
REQ-018 Arbitration: round-robin, one-bit last_grant pointer; when both requesters valid, grant goes to the one not granted last; a lone valid requester is granted.
REQ-019 last_grant updates only on an accepted dcache request.
REQ-020 dc_req_valid = granted requester valid & cnt < DEPTH; payload is a combinational mux of the granted requester's fields.
REQ-021 mX_req_ready = granted(X) & cnt < DEPTH & dc_req_ready; never asserted for the non-granted requester.
REQ-022 The grant is held (no re-arbitration) while dc_req_valid is high and dc_req_ready is low; the payload is stable until accepted.
REQ-023 While flush_i is high, m0 is not granted and m0_req_ready = 0; m1 arbitration is unaffected.
REQ-024 Flush marks every FIFO entry with src=0 killed=1, including an entry pushed in the same cycle.
REQ-025 Head entry not killed: dc_resp_ready = ready of the head's src; that requester's resp_valid = dc_resp_valid; resp_data = dc_resp_data; the other requester's resp_valid = 0.
REQ-026 Head entry killed: dc_resp_ready = 1, response discarded, m0_resp_valid = 0.
REQ-027 dc_resp_valid with cnt == 0: dc_resp_ready = 1, response dropped, err_o set; err_o is cleared only by reset.
REQ-028 busy_o = (cnt != 0), registered-state derived, no combinational path from inputs.
REQ-029 Latency: zero added cycles on both the request and the response paths (pure combinational forwarding plus state update).

Reset
REQ-030 rst_n low: cnt = 0, FIFO pointers = 0, last_grant = 1 (m0 wins first tie), err_o = 0, busy_o = 0.
REQ-031 During reset all valid/ready outputs are 0; in-flight dcache responses arriving after deassertion with cnt = 0 set err_o (the dcache is reset together with this block).

Verification
REQ-032 Both requesters are held valid with dc_req_ready = 1 and immediate responses -> grants alternate m0,m1,m0,m1; each response is routed to the matching src.
REQ-033 DEPTH=2 and dc_resp_valid = 0 with m0 issuing -> 2 accepts, then m0_req_ready = 0; one response -> exactly one further accept in the following cycle, none in the same cycle.
REQ-034 m0 has 2 requests in flight and flush_i is pulsed for one cycle -> both responses consumed with dc_resp_ready = 1, m0_resp_valid stays 0, cnt returns to 0.
REQ-035 In-flight order m0,m1; flush; responses arrive -> first response is discarded, second is delivered on m1 with data intact.
REQ-036 dc_req_ready = 0 for 3 cycles while m1 is granted and m0 asserts valid -> grant and payload remain m1 until accepted.
REQ-037 Spurious dc_resp_valid with cnt = 0 -> err_o = 1 next cycle and held until rst_n is asserted.
